// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  // Canonical RISC-V NOP (addi x0, x0, 0) loaded by a flushed register.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int MEM_TIMEOUT_DEF = 64;

  // True when the load in EX writes a register the decode instruction reads.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    return mem_read && (rd != 5'd0) &&
           ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall-cycle and flush-cycle performance counters for the hazard sequencer.
// Instantiated only when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters wrap naturally at 2^CNT_W.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_i) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_i) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use stalls,
// taken-branch flushes, multi-cycle MUL/DIV issue and data-memory waits
// with a timeout guard. Optional macro HAZARD_PERF_CNT_EN adds the
// stallCycles/flushCount performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_IDrs1,
  input  logic [4:0]       IF_IDrs2,
  input  logic             IF_IDusesRs2,
  input  logic [4:0]       ID_EXrd,
  input  logic             ID_EXmemRead,
  input  logic             ID_EXmduOp,
  input  logic             branchTaken,
  input  logic             EX_MEMmemReq,
  input  logic             dmemReady,
  input  logic             mduDone,
  output logic             PCwrite,
  output logic             IF_IDwrite,
  output logic             ID_EXwrite,
  output logic             EX_MEMwrite,
  output logic             MEM_WBwrite,
  output logic             IF_IDflush,
  output logic             ID_EXflush,
  output logic             EX_MEMflush,
  output logic             MEM_WBflush,
  output logic             mduStart,
  output logic             memFault
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
`endif
);

  localparam int TIMEOUT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;

  hz_state_e            state_q, state_d;
  hz_state_e            ret_q, ret_d;     // state to resume after a memory wait
  hz_state_e            eff_state;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 mem_stall;
  logic                 lu_hit;

  function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
    return (v == TMO_MAX) ? v : v + 1'b1;
  endfunction

  assign mem_stall = EX_MEMmemReq && !dmemReady;
  assign lu_hit    = load_use_hit(ID_EXmemRead, ID_EXrd, IF_IDrs1, IF_IDrs2, IF_IDusesRs2);
  // While parked in MEM_WAIT, a release is handled as the interrupted state.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  // Next-state and enable/flush decode, priority memory > MDU > branch > load-use.
  always_comb begin
    PCwrite     = 1'b1;
    IF_IDwrite  = 1'b1;
    ID_EXwrite  = 1'b1;
    EX_MEMwrite = 1'b1;
    MEM_WBwrite = 1'b1;
    IF_IDflush  = 1'b0;
    ID_EXflush  = 1'b0;
    EX_MEMflush = 1'b0;
    MEM_WBflush = 1'b0;
    mduStart    = 1'b0;
    memFault    = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    tmo_d       = '0;

    if (mem_stall) begin
      PCwrite     = 1'b0;
      IF_IDwrite  = 1'b0;
      ID_EXwrite  = 1'b0;
      EX_MEMwrite = 1'b0;
      MEM_WBwrite = 1'b0;
      if ((state_q == MEM_WAIT) && (tmo_q == TMO_LAST)) begin
        // Give up on the access: bubble MEM/WB and resume normal flow.
        MEM_WBwrite = 1'b1;
        MEM_WBflush = 1'b1;
        memFault    = 1'b1;
        state_d     = RUN;
        ret_d       = RUN;
      end else begin
        state_d = MEM_WAIT;
        ret_d   = eff_state;
        tmo_d   = sat_inc(tmo_q);
      end
    end else begin
      state_d = eff_state;
      case (eff_state)
        MDU_WAIT: begin
          if (mduDone) begin
            state_d = RUN;
          end else begin
            PCwrite     = 1'b0;
            IF_IDwrite  = 1'b0;
            ID_EXwrite  = 1'b0;
            EX_MEMflush = 1'b1;
          end
        end
        default: begin
          if (ID_EXmduOp) begin
            mduStart    = 1'b1;
            PCwrite     = 1'b0;
            IF_IDwrite  = 1'b0;
            ID_EXwrite  = 1'b0;
            EX_MEMflush = 1'b1;
            state_d     = MDU_WAIT;
          end else if (branchTaken) begin
            IF_IDflush = 1'b1;
            ID_EXflush = 1'b1;
          end else if (lu_hit) begin
            PCwrite    = 1'b0;
            IF_IDwrite = 1'b0;
            ID_EXflush = 1'b1;
          end
        end
      endcase
    end
  end

  // State, return-state and timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (!PCwrite),
    .flush_i    (IF_IDflush || ID_EXflush),
    .stall_cnt_o(stallCycles),
    .flush_cnt_o(flushCount)
  );
`else
  // CNT_W only sizes the counter ports, which are absent in this build.
  wire unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (built with MEM_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 8;
  localparam int CW  = 32;

  // Output vector order: {PC, IF_ID, ID_EX, EX_MEM, MEM_WB write,
  //                       IF_ID, ID_EX, EX_MEM, MEM_WB flush, mduStart, memFault}
  localparam logic [10:0] E_RUN  = 11'b11111_0000_00;
  localparam logic [10:0] E_LU   = 11'b00111_0100_00;
  localparam logic [10:0] E_BR   = 11'b11111_1100_00;
  localparam logic [10:0] E_MDUS = 11'b00011_0010_10;
  localparam logic [10:0] E_MDUW = 11'b00011_0010_00;
  localparam logic [10:0] E_FRZ  = 11'b00000_0000_00;
  localparam logic [10:0] E_FLT  = 11'b00001_0001_01;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       mrd;
    logic       mdu;
    logic       br;
    logic       mreq;
    logic       rdy;
    logic       done;
  } in_t;

  typedef struct {
    in_t         in;
    logic [10:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] IF_IDrs1, IF_IDrs2, ID_EXrd;
  logic IF_IDusesRs2, ID_EXmemRead, ID_EXmduOp, branchTaken;
  logic EX_MEMmemReq, dmemReady, mduDone;
  logic PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, MEM_WBwrite;
  logic IF_IDflush, ID_EXflush, EX_MEMflush, MEM_WBflush, mduStart, memFault;
  logic [10:0] dut_out;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  string       nm_q[$];

`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stallCycles, flushCount;
  logic [CW-1:0] stall_m = '0;
  logic [CW-1:0] flush_m = '0;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IF_IDrs1    (IF_IDrs1),
    .IF_IDrs2    (IF_IDrs2),
    .IF_IDusesRs2(IF_IDusesRs2),
    .ID_EXrd     (ID_EXrd),
    .ID_EXmemRead(ID_EXmemRead),
    .ID_EXmduOp  (ID_EXmduOp),
    .branchTaken (branchTaken),
    .EX_MEMmemReq(EX_MEMmemReq),
    .dmemReady   (dmemReady),
    .mduDone     (mduDone),
    .PCwrite     (PCwrite),
    .IF_IDwrite  (IF_IDwrite),
    .ID_EXwrite  (ID_EXwrite),
    .EX_MEMwrite (EX_MEMwrite),
    .MEM_WBwrite (MEM_WBwrite),
    .IF_IDflush  (IF_IDflush),
    .ID_EXflush  (ID_EXflush),
    .EX_MEMflush (EX_MEMflush),
    .MEM_WBflush (MEM_WBflush),
    .mduStart    (mduStart),
    .memFault    (memFault)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stallCycles (stallCycles),
    .flushCount  (flushCount)
`endif
  );

  assign dut_out = {PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, MEM_WBwrite,
                    IF_IDflush, ID_EXflush, EX_MEMflush, MEM_WBflush, mduStart, memFault};

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic mrd, input logic mdu,
                             input logic br, input logic mreq, input logic rdy,
                             input logic done);
    in_t v;
    v = '{rs1: rs1, rs2: rs2, u2: u2, rd: rd, mrd: mrd, mdu: mdu, br: br,
          mreq: mreq, rdy: rdy, done: done};
    return v;
  endfunction

  task automatic apply(input in_t v);
    IF_IDrs1     = v.rs1;
    IF_IDrs2     = v.rs2;
    IF_IDusesRs2 = v.u2;
    ID_EXrd      = v.rd;
    ID_EXmemRead = v.mrd;
    ID_EXmduOp   = v.mdu;
    branchTaken  = v.br;
    EX_MEMmemReq = v.mreq;
    dmemReady    = v.rdy;
    mduDone      = v.done;
  endtask

  task automatic cmp(input string n, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, got, want);
    end
  endtask

  task automatic cmp32(input string n, input logic [CW-1:0] got, input logic [CW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, want);
    end
  endtask

  // One cycle: drive at posedge+1, score at the falling edge, advance.
  task automatic step(input in_t v, input logic [10:0] e, input string nm);
    logic [10:0] ex;
    string       n;
    apply(v);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    #4;
    ex = exp_q.pop_front();
    n  = nm_q.pop_front();
    cmp(n, dut_out, ex);
`ifdef HAZARD_PERF_CNT_EN
    if (!e[10]) stall_m++;
    if (e[5] || e[4]) flush_m++;
`endif
    @(posedge clk);
    #1;
  endtask

  in_t  IDLE;
  in_t  MREQ_WAIT;
  vec_t vecs[10];

  initial begin
    IDLE      = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    MREQ_WAIT = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Single-cycle RUN-state decode cases; none of them leaves RUN.
    vecs[0] = '{IDLE, E_RUN};
    vecs[1] = '{mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_LU};
    vecs[2] = '{mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_RUN};
    vecs[3] = '{mk(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_RUN};
    vecs[4] = '{mk(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_LU};
    vecs[5] = '{mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_RUN};
    vecs[6] = '{mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), E_BR};
    vecs[7] = '{mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), E_BR};
    vecs[8] = '{mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), E_RUN};
    vecs[9] = '{mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), E_RUN};

    // Reset state.
    rst_n = 1'b0;
    apply(IDLE);
    #2;
    cmp("reset_outputs", dut_out, E_RUN);
`ifdef HAZARD_PERF_CNT_EN
    cmp32("reset_stall_cnt", stallCycles, '0);
    cmp32("reset_flush_cnt", flushCount, '0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));

    // Load-use stalls exactly one cycle; the bubble then clears the hazard.
    step(mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_LU, "lu_stall");
    step(mk(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_RUN, "lu_after");

    // MDU: one start pulse, four more held cycles, release on mduDone.
    step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), E_MDUS, "mdu_start");
    for (int i = 0; i < 4; i++)
      step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, (i == 2), 1'b0, 1'b1, 1'b0), E_MDUW,
           $sformatf("mdu_wait%0d", i));
    step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1), E_RUN, "mdu_done");
    step(IDLE, E_RUN, "mdu_after");

    // Memory wait while in MDU_WAIT returns to MDU_WAIT.
    step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), E_MDUS, "mm_start");
    step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), E_MDUW, "mm_wait");
    for (int i = 0; i < 3; i++) step(MREQ_WAIT, E_FRZ, $sformatf("mm_freeze%0d", i));
    step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), E_MDUW, "mm_resume");
    step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1), E_RUN, "mm_done");

    // Memory wait from RUN; release cycle evaluates RUN hazards.
    step(MREQ_WAIT, E_FRZ, "mr_freeze0");
    step(MREQ_WAIT, E_FRZ, "mr_freeze1");
    step(mk(5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), E_LU, "mr_release_lu");

    // Timeout: fault on the 8th waiting cycle, then back in RUN.
    for (int i = 0; i < TMO - 1; i++) step(MREQ_WAIT, E_FRZ, $sformatf("tmo_freeze%0d", i));
    step(MREQ_WAIT, E_FLT, "tmo_fault");
    step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), E_MDUS, "tmo_run");
    step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1), E_RUN, "tmo_mdu_done");
    step(MREQ_WAIT, E_FRZ, "tmo_rewait");
    step(IDLE, E_RUN, "tmo_clear");

`ifdef HAZARD_PERF_CNT_EN
    cmp32("stall_cnt", stallCycles, stall_m);
    cmp32("flush_cnt", flushCount, flush_m);
`endif

    // Reset in MDU_WAIT abandons the operation immediately.
    step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), E_MDUS, "rst_mdu_start");
    step(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), E_MDUW, "rst_mdu_wait");
    apply(IDLE);
    rst_n = 1'b0;
    #1;
    cmp("rst_mid_run", dut_out, E_RUN);
`ifdef HAZARD_PERF_CNT_EN
    cmp32("rst_mid_stall_cnt", stallCycles, '0);
    cmp32("rst_mid_flush_cnt", flushCount, '0);
    stall_m = '0;
    flush_m = '0;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(IDLE, E_RUN, "post_reset_run");
    step(mk(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_LU, "post_reset_lu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline. It sits beside the forwarding logic and decides, every cycle, which pipeline registers advance, hold or are bubbled. It covers load-use hazards, taken-branch flushes, multi-cycle MUL/DIV issue and data-memory wait states, with a timeout guard on the memory handshake. Forwarding-mux selects stay in the forwarding block; this block owns only enables and flushes.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum consecutive cycles of an outstanding data-memory access before a fault is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_IDrs1, IF_IDrs2  in  5 each  source registers of the instruction in decode.
- IF_IDusesRs2  in  1  the decode instruction reads rs2.
- ID_EXrd  in  5  destination register in EX.
- ID_EXmemRead  in  1  the EX instruction is a load.
- ID_EXmduOp  in  1  the EX instruction is MUL/DIV.
- branchTaken  in  1  branch or jump resolved taken in EX.
- EX_MEMmemReq  in  1  the MEM-stage instruction accesses data memory.
- dmemReady  in  1  data memory completes the access this cycle.
- mduDone  in  1  multiply/divide result is valid this cycle.
- PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, MEM_WBwrite  out  1 each  register enables.
- IF_IDflush, ID_EXflush, EX_MEMflush, MEM_WBflush  out  1 each  load a bubble (NOP) into the register.
- mduStart  out  1  one-cycle start pulse to the MDU.
- memFault  out  1  one-cycle pulse when the memory access times out.
- stallCycles, flushCount  out  CNT_W each  performance counters (present only with the macro defined).

## Operation
- States: RUN, MDU_WAIT, MEM_WAIT. Reset state: RUN.
- Default outputs in RUN with no event: all enables 1, all flushes 0, mduStart 0, memFault 0.
- Priority, highest first: memory wait, MDU, branch flush, load-use stall.
- **Memory wait**, evaluated in any state:
  - Condition: EX_MEMmemReq && !dmemReady.
  - All enables are 0 and all flushes are 0, so the whole pipeline freezes.
  - Next state is MEM_WAIT and the timeout counter increments.
  - When dmemReady rises, the pipeline releases in that same cycle and the FSM returns to the state it was in before MEM_WAIT.
  - If the counter reaches MEM_TIMEOUT-1 while still waiting: memFault pulses, MEM_WBflush is 1, MEM_WBwrite is 1, the FSM returns to RUN and the counter clears.
- **MDU**, evaluated in RUN:
  - Condition: ID_EXmduOp.
  - mduStart pulses.
  - PCwrite, IF_IDwrite and ID_EXwrite are 0. EX_MEMflush is 1. Next state is MDU_WAIT.
- **MDU_WAIT**:
  - Same outputs as the MDU case, but mduStart is 0.
  - When mduDone is 1, all enables are 1 and no flush is asserted, so the result advances into EX/MEM. Next state is RUN.
- **Branch flush**, in RUN:
  - Condition: branchTaken.
  - IF_IDflush is 1, ID_EXflush is 1, PCwrite is 1.
  - A load-use hazard in the same cycle is ignored.
- **Load-use stall**, in RUN:
  - Condition: ID_EXmemRead && ID_EXrd!=0 && (ID_EXrd==IF_IDrs1 || (IF_IDusesRs2 && ID_EXrd==IF_IDrs2)).
  - PCwrite is 0, IF_IDwrite is 0, ID_EXflush is 1.
- A flush on a register overrides its enable: the register loads the NOP.

## Timing
- All outputs are combinational from the current state and inputs, with zero latency.
- State, the timeout counter and the performance counters are registered.
- mduStart is asserted in exactly one cycle per MDU instruction.
- mduDone is ignored outside MDU_WAIT.
- Reset mid-operation: the FSM goes to RUN, counters clear, and any pending MDU or memory wait is abandoned.
- The timeout counter is TIMEOUT_W = $clog2(MEM_TIMEOUT) bits wide and saturates; it clears whenever the FSM is not in MEM_WAIT.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stallCycles increments on every cycle with PCwrite == 0.
  - flushCount increments on every cycle with IF_IDflush or ID_EXflush asserted.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Not defined: both ports are absent and no counter logic exists.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, MDU_WAIT, MEM_WAIT)
  - the NOP encoding 32'h00000013
  - the default MEM_TIMEOUT constant
- Sub-module hazard_perf_counters contains both counters and is instantiated only under HAZARD_PERF_CNT_EN.

## Test plan
- Load x5 in EX, decode reads rs1=x5 -> exactly one cycle with PCwrite=0, IF_IDwrite=0, ID_EXflush=1, then normal flow; repeat with rd=x0 -> no stall.
- branchTaken=1 together with a load-use match -> IF_IDflush=1, ID_EXflush=1, PCwrite=1, no stall.
- ID_EXmduOp=1, mduDone after 5 cycles -> mduStart pulses once; 5 cycles with PCwrite=0 and EX_MEMflush=1; enables all 1 in the mduDone cycle.
- EX_MEMmemReq=1 with dmemReady low for 3 cycles while in MDU_WAIT -> all enables 0 for 3 cycles, then return to MDU_WAIT.
- dmemReady held low with MEM_TIMEOUT=8 -> memFault pulses on the 8th cycle, MEM_WBflush=1, state RUN.
- rst_n asserted in MDU_WAIT -> state RUN immediately; with macro defined, stallCycles=0 and flushCount=0.
